// File: rtl/mvm_stream_driver_if.sv
// Bus bundle for mvm_stream_driver: upstream element input, downstream result
// output and the serial link to the MVM engine.
interface mvm_stream_driver_if #(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [INPUT_WIDTH-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUTPUT_WIDTH-1:0] out_data;
    logic                    mvm_start;
    logic [INPUT_WIDTH-1:0]  mvm_data_in;
    logic                    mvm_done;
    logic [OUTPUT_WIDTH-1:0] mvm_data_out;

    modport master (
        input  in_valid, in_data, out_ready, mvm_done, mvm_data_out,
        output in_ready, out_valid, out_data, mvm_start, mvm_data_in
    );

    modport slave (
        output in_valid, in_data, out_ready, mvm_done, mvm_data_out,
        input  in_ready, out_valid, out_data, mvm_start, mvm_data_in
    );
endinterface

// File: rtl/mvm_stream_driver.sv
// Job initiator for the MVM engine: buffers A and x, streams them gap-free after
// a start pulse, captures the result burst and returns y. Optional MVM_TIMEOUT_EN.
module mvm_stream_driver #(
    parameter int unsigned MAT_SCALE    = 4,
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 16,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                clk,
    input  logic                reset,
    mvm_stream_driver_if.master bus,
    output logic                busy,
    output logic                err
);
    localparam int unsigned N   = MAT_SCALE * MAT_SCALE + MAT_SCALE;
    localparam int unsigned CW  = $clog2(N + 1);
    localparam int unsigned BAW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RAW = (MAT_SCALE > 1) ? $clog2(MAT_SCALE) : 1;
`ifdef MVM_TIMEOUT_EN
    localparam int unsigned WCW = $clog2(TIMEOUT + 1);
`endif

    if (MAT_SCALE == 0 || TIMEOUT == 0) begin : g_param_check
        $error("mvm_stream_driver: MAT_SCALE and TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        START   = 3'd1,
        STREAM  = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           idx_q, idx_d;
    logic [INPUT_WIDTH-1:0]  buf_q [N];
    logic [INPUT_WIDTH-1:0]  buf_d [N];
    logic [OUTPUT_WIDTH-1:0] res_q [MAT_SCALE];
    logic [OUTPUT_WIDTH-1:0] res_d [MAT_SCALE];
    logic                    out_valid_q, out_valid_d;
    logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                    mvm_start_q, mvm_start_d;
    logic [INPUT_WIDTH-1:0]  mvm_data_in_q, mvm_data_in_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    in_ready_c;
`ifdef MVM_TIMEOUT_EN
    logic [WCW-1:0]          wait_cnt_q, wait_cnt_d;
`endif

    // Held low during reset so nothing is accepted while the block is held off.
    assign in_ready_c       = (state_q == LOAD) && !reset;
    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.mvm_start    = mvm_start_q;
    assign bus.mvm_data_in  = mvm_data_in_q;
    assign busy             = busy_q;
    assign err              = err_q;

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        buf_d         = buf_q;
        res_d         = res_q;
        out_valid_d   = 1'b0;
        out_data_d    = out_data_q;
        mvm_start_d   = 1'b0;
        mvm_data_in_d = '0;
        err_d         = err_q;
`ifdef MVM_TIMEOUT_EN
        wait_cnt_d    = '0;
`endif
        case (state_q)
            LOAD: begin
                if (bus.in_valid && in_ready_c) begin
                    buf_d[BAW'(idx_q)] = bus.in_data;
                    if (idx_q == CW'(N - 1)) begin
                        idx_d       = '0;
                        state_d     = START;
                        mvm_start_d = 1'b1;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            START: begin
                mvm_data_in_d = buf_q[0];
                idx_d         = CW'(1);
                state_d       = STREAM;
            end
            // idx_q leads the element on the wire by one
            STREAM: begin
                if (idx_q == CW'(N)) begin
                    idx_d   = '0;
                    state_d = WAIT;
                end else begin
                    mvm_data_in_d = buf_q[BAW'(idx_q)];
                    idx_d         = idx_q + CW'(1);
                end
            end
            WAIT: begin
                if (bus.mvm_done) begin
                    idx_d   = '0;
                    state_d = CAPTURE;
                end
`ifdef MVM_TIMEOUT_EN
                else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
`endif
            end
            CAPTURE: begin
                res_d[RAW'(idx_q)] = bus.mvm_data_out;
                if (idx_q == CW'(MAT_SCALE - 1)) begin
                    idx_d       = '0;
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    out_data_d  = res_d[0];
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            DRAIN: begin
                out_valid_d = 1'b1;
                if (bus.out_ready) begin
                    if (idx_q == CW'(MAT_SCALE - 1)) begin
                        out_valid_d = 1'b0;
                        idx_d       = '0;
                        state_d     = LOAD;
                    end else begin
                        idx_d      = idx_q + CW'(1);
                        out_data_d = res_q[RAW'(idx_q + CW'(1))];
                    end
                end
            end
            default: state_d = LOAD;
        endcase
        busy_d = (state_d != LOAD);
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= LOAD;
            idx_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            mvm_start_q   <= 1'b0;
            mvm_data_in_q <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            mvm_start_q   <= mvm_start_d;
            mvm_data_in_q <= mvm_data_in_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

`ifdef MVM_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // Job and result storage keep their contents across reset
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        res_q <= res_d;
    end
endmodule

// File: tb/tb_mvm_stream_driver.sv
// Self-checking bench for mvm_stream_driver: drives jobs, models the engine with
// a plain matrix-vector product and checks stream timing and returned results.
`timescale 1ns/1ps
module tb_mvm_stream_driver;
    localparam int unsigned M  = 4;
    localparam int unsigned IW = 8;
    localparam int unsigned OW = 16;
    localparam int unsigned N  = M * M + M;
    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic err;

    mvm_stream_driver_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

    mvm_stream_driver #(
        .MAT_SCALE(M), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .err(err)
    );

    initial forever #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic        exp_err;
    logic [IW-1:0] job [N];
    logic [OW-1:0] y   [M];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference result: y = A*x over signed elements, truncated to the result width
    task automatic calc_y();
        for (int j = 0; j < int'(M); j++) begin
            int acc;
            acc = 0;
            for (int i = 0; i < int'(M); i++)
                acc = acc + int'($signed(job[j*M+i])) * int'($signed(job[M*M+i]));
            y[j] = OW'(acc);
        end
    endtask

    task automatic rand_job();
        for (int k = 0; k < int'(N); k++) job[k] = IW'($urandom);
        calc_y();
    endtask

    task automatic ident_job(input int x0, input int x1, input int x2, input int x3);
        for (int j = 0; j < int'(M); j++)
            for (int i = 0; i < int'(M); i++) job[j*M+i] = (i == j) ? IW'(1) : IW'(0);
        job[M*M+0] = IW'(x0); job[M*M+1] = IW'(x1);
        job[M*M+2] = IW'(x2); job[M*M+3] = IW'(x3);
        calc_y();
    endtask

    // vmode: 0 valid held, 1 toggling, 2 random. abort_at >= 0 resets mid-stream.
    task automatic do_job(input int vmode, input int stall0, input bit rmode, input int done_dly,
                          input bit stray, input int abort_at, input bit no_done);
        int k, cyc, j;
        k = 0; cyc = 0;
        while (k < int'(N)) begin
            bit v;
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.in_data  = v ? job[k] : IW'($urandom);
            chk("load_in_ready", 32'(bus.in_ready), 32'd1);
            step();
            if (v) k++;
            cyc++;
            if (cyc > 10 * int'(N)) begin
                chk("load_budget", 32'(k), 32'(N));
                break;
            end
        end
        bus.in_valid = 1'b0;
        chk("start_pulse", 32'(bus.mvm_start), 32'd1);
        chk("start_data", 32'(bus.mvm_data_in), 32'd0);
        chk("start_in_ready", 32'(bus.in_ready), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        for (int s = 0; s < int'(N); s++) begin
            step();
            bus.mvm_done = stray && (s == 5);
            chk("stream_data", 32'(bus.mvm_data_in), 32'(job[s]));
            chk("stream_start_low", 32'(bus.mvm_start), 32'd0);
            chk("stream_in_ready", 32'(bus.in_ready), 32'd0);
            if (s == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_mvm_data_in", 32'(bus.mvm_data_in), 32'd0);
                chk("abort_mvm_start", 32'(bus.mvm_start), 32'd0);
                chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
                chk("abort_err", 32'(err), 32'd0);
                bus.mvm_done = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                exp_err = 1'b0;
                #1;
                chk("abort_release_in_ready", 32'(bus.in_ready), 32'd1);
                return;
            end
        end
        step();
        bus.mvm_done = 1'b0;
        chk("wait_data_zero", 32'(bus.mvm_data_in), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
`ifdef MVM_TIMEOUT_EN
        if (no_done) begin
            for (int w = 0; w < int'(TO); w++) begin
                chk("wait_err_low", 32'(err), 32'(exp_err));
                chk("wait_in_ready", 32'(bus.in_ready), 32'd0);
                chk("wait_out_valid", 32'(bus.out_valid), 32'd0);
                bus.mvm_data_out = OW'($urandom);
                step();
            end
            exp_err = 1'b1;
            chk("timeout_err", 32'(err), 32'd1);
            chk("timeout_in_ready", 32'(bus.in_ready), 32'd1);
            chk("timeout_busy", 32'(busy), 32'd0);
            chk("timeout_out_valid", 32'(bus.out_valid), 32'd0);
            return;
        end
`endif
        for (int w = 0; w < done_dly; w++) begin
            chk("wait_out_valid", 32'(bus.out_valid), 32'd0);
            bus.mvm_data_out = OW'($urandom);
            step();
        end
        bus.mvm_done = 1'b1;
        bus.mvm_data_out = OW'($urandom);
        step();
        bus.mvm_done = 1'b0;
        for (int c = 0; c < int'(M); c++) begin
            bus.mvm_data_out = y[c];
            chk("capture_out_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        bus.mvm_data_out = OW'($urandom);
        j = 0; cyc = 0;
        while (j < int'(M) && cyc < stall0 + 20 * int'(M)) begin
            bit r;
            r = (cyc < stall0) ? 1'b0 : (rmode ? 1'($urandom_range(0, 1)) : 1'b1);
            bus.out_ready = r;
            chk("drain_out_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_out_data", 32'(bus.out_data), 32'(y[j]));
            chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
            step();
            if (r) j++;
            cyc++;
        end
        bus.out_ready = 1'b0;
        chk("drain_count", 32'(j), 32'(M));
        chk("end_out_valid", 32'(bus.out_valid), 32'd0);
        chk("end_in_ready", 32'(bus.in_ready), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_fail = 0; exp_err = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.mvm_done = 1'b0; bus.mvm_data_out = '0;
        #3;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mvm_start", 32'(bus.mvm_start), 32'd0);
        chk("rst_mvm_data_in", 32'(bus.mvm_data_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        ident_job(1, 2, 3, 4);
        do_job(0, 0, 1'b0, 3, 1'b0, -1, 1'b0);

        for (int j = 0; j < int'(M); j++) begin
            for (int i = 0; i < int'(M); i++) job[j*M+i] = IW'(j + 1);
            job[M*M+j] = IW'(1);
        end
        calc_y();
        do_job(1, 0, 1'b0, 5, 1'b0, -1, 1'b0);

        for (int k = 0; k < int'(M*M); k++) job[k] = IW'(-3);
        job[M*M+0] = IW'(5); job[M*M+1] = IW'(-5); job[M*M+2] = IW'(7); job[M*M+3] = IW'(-7);
        calc_y();
        do_job(0, 10, 1'b0, 2, 1'b0, -1, 1'b0);

        rand_job();
        job[7] = IW'(8'h5a);
        do_job(0, 0, 1'b0, 0, 1'b0, 7, 1'b0);
        ident_job(-8, 0, 8, 127);
        do_job(0, 0, 1'b0, 1, 1'b0, -1, 1'b0);

        rand_job();
        do_job(2, 0, 1'b0, 4, 1'b1, -1, 1'b0);

`ifdef MVM_TIMEOUT_EN
        rand_job();
        do_job(0, 0, 1'b0, 0, 1'b0, -1, 1'b1);
        rand_job();
        do_job(0, 0, 1'b0, 3, 1'b0, -1, 1'b0);
`endif

        for (int t = 0; t < 6; t++) begin
            rand_job();
            do_job(2, $urandom_range(0, 6), 1'b1, $urandom_range(0, 20), 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
